fetch: RTL

Instruction fetch stage of the in-order pipeline, feeding the decode stage. It owns the program counter and drives the instruction memory read port. It delivers each instruction's PC and a bubble flag to decode, aligned with the instruction word that memory returns two cycles later. It honours decode's stall, execute's branch redirect (flush) and the global halt.

---
 rtl/fetch.sv | 65 ++++++
 1 files changed

// File: rtl/fetch.sv
// fetch: in-order pipeline fetch stage owning the PC and tracking two in-flight memory reads
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic [31:0] mem_addr,
    output logic        mem_en,
    output logic [31:0] pc_out,
    output logic        bubble_out,
    output logic        misalign
);
    logic [31:0] fetch_pc_q, fetch_pc_d, pc1_q, pc1_d, pc2_q, pc2_d;
    logic        bub1_q, bub1_d, bub2_q, bub2_d, mis_q, mis_d;
    assign mem_en     = !stall && !halt && !reset;
    assign mem_addr   = fetch_pc_q;
    assign pc_out     = pc2_q;
    assign bubble_out = bub2_q;
    assign misalign   = mis_q;
    // next state: halt freezes, flush redirects and drains slots, stall holds, otherwise shift the read pipe
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc1_d      = pc1_q;
        bub1_d     = bub1_q;
        pc2_d      = pc2_q;
        bub2_d     = bub2_q;
        mis_d      = mis_q;
        if (!halt && flush) begin
            fetch_pc_d = {branch_target[31:2], 2'b00};
            pc1_d      = '0;
            bub1_d     = 1'b1;
            pc2_d      = '0;
            bub2_d     = 1'b1;
            mis_d      = mis_q | (branch_target[1:0] != 2'b00);
        end else if (!halt && !stall) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pc1_d      = fetch_pc_q;
            bub1_d     = 1'b0;
            pc2_d      = pc1_q;
            bub2_d     = bub1_q;
        end
    end
    // state registers with synchronous reset that empties both in-flight slots
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pc1_q      <= '0;
            bub1_q     <= 1'b1;
            pc2_q      <= '0;
            bub2_q     <= 1'b1;
            mis_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc1_q      <= pc1_d;
            bub1_q     <= bub1_d;
            pc2_q      <= pc2_d;
            bub2_q     <= bub2_d;
            mis_q      <= mis_d;
        end
    end
endmodule
